// File: rtl/sprite_layer_renderer_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_layer_renderer_if
// Purpose  : Groups the sprite configuration write port and the per-channel
//            sprite ROM bus of the sprite layer renderer.
// Signals  : cfg_we/cfg_sel/cfg_x/cfg_y/cfg_en/cfg_flip - shadow config write
//            rom_addr - per-channel ROM address (channel k = slice k)
//            rom_q    - per-channel ROM data, 1-cycle synchronous read
// Modports : master - configuration source and ROM owner
//            slave  - the renderer
// Revision : 1.0 - initial release
// ============================================================================
interface sprite_layer_renderer_if #(
  parameter int N_SPR  = 4,
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 12
);
  localparam int ID_W = (N_SPR > 1) ? $clog2(N_SPR) : 1;

  logic                    cfg_we;
  logic [ID_W-1:0]         cfg_sel;
  logic [9:0]              cfg_x;
  logic [9:0]              cfg_y;
  logic                    cfg_en;
  logic                    cfg_flip;
  logic [N_SPR*ADDR_W-1:0] rom_addr;
  logic [N_SPR*IDX_W-1:0]  rom_q;

  modport master (
    output cfg_we, cfg_sel, cfg_x, cfg_y, cfg_en, cfg_flip, rom_q,
    input  rom_addr
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_x, cfg_y, cfg_en, cfg_flip, rom_q,
    output rom_addr
  );
endinterface
`default_nettype wire

// File: rtl/sprite_layer_renderer.sv
`default_nettype none
// ============================================================================
// Module   : sprite_layer_renderer
// Purpose  : Overlays up to N_SPR sprites (SPR_W x SPR_H) on the VGA raster.
//            Per-sprite X-flip, transparent index, fixed priority (lowest
//            channel wins). Sprite placement is double-buffered: writes land
//            in a shadow copy that becomes active on frame_start.
// Ports    : vga_clk     - pixel clock
//            reset_n     - asynchronous active-low reset
//            DrawX/DrawY - current raster position
//            frame_start - copies shadow config to active
//            bus         - config write port and per-channel ROM bus (slave)
//            pix_idx     - winning palette index (registered)
//            spr_id      - winning channel (registered)
//            sprite_on   - an opaque sprite pixel is present (registered)
// Latency  : outputs belong to the DrawX/DrawY presented 2 cycles earlier.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_layer_renderer #(
  parameter int N_SPR  = 4,
  parameter int SPR_W  = 55,
  parameter int SPR_H  = 55,
  parameter int IDX_W  = 4,
  parameter int TRANS  = 0,
  parameter int ADDR_W = 12
) (
  input  logic                        vga_clk,
  input  logic                        reset_n,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic                        frame_start,
  sprite_layer_renderer_if.slave      bus,
  output logic [IDX_W-1:0]            pix_idx,
  output logic [((N_SPR > 1) ? $clog2(N_SPR) : 1)-1:0] spr_id,
  output logic                        sprite_on
);

  localparam int ID_W = (N_SPR > 1) ? $clog2(N_SPR) : 1;

  localparam logic [10:0]      C_SPR_W = 11'(SPR_W);
  localparam logic [10:0]      C_SPR_H = 11'(SPR_H);
  localparam logic [IDX_W-1:0] C_TRANS = IDX_W'(TRANS);
  localparam logic [ID_W:0]    C_NSPR  = (ID_W + 1)'(N_SPR);

  // shadow (written by cfg port) and active (used by hit test) config
  logic [9:0] r_sh_x    [N_SPR];
  logic [9:0] r_sh_y    [N_SPR];
  logic       r_sh_en   [N_SPR];
  logic       r_sh_flip [N_SPR];
  logic [9:0] r_act_x    [N_SPR];
  logic [9:0] r_act_y    [N_SPR];
  logic       r_act_en   [N_SPR];
  logic       r_act_flip [N_SPR];

  logic              w_sel_ok;
  logic [N_SPR-1:0]  w_hit;
  logic [N_SPR-1:0]  r_hit_d;
  logic [N_SPR-1:0]  w_opaque;
  logic [IDX_W-1:0]  w_q [N_SPR];

  logic              w_win_on;
  logic [ID_W-1:0]   w_win_id;
  logic [IDX_W-1:0]  w_win_idx;

  // Channel numbers beyond N_SPR are possible when N_SPR is not a power of 2
  assign w_sel_ok = ({1'b0, bus.cfg_sel} < C_NSPR);

  // --------------------------------------------------------------------------
  // Configuration: non-blocking copy means a write coinciding with
  // frame_start reaches shadow only; active picks up the old shadow value.
  // --------------------------------------------------------------------------
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_SPR; k++) begin
        r_sh_x[k]     <= '0;
        r_sh_y[k]     <= '0;
        r_sh_en[k]    <= 1'b0;
        r_sh_flip[k]  <= 1'b0;
        r_act_x[k]    <= '0;
        r_act_y[k]    <= '0;
        r_act_en[k]   <= 1'b0;
        r_act_flip[k] <= 1'b0;
      end
    end else begin
      if (frame_start) begin
        for (int k = 0; k < N_SPR; k++) begin
          r_act_x[k]    <= r_sh_x[k];
          r_act_y[k]    <= r_sh_y[k];
          r_act_en[k]   <= r_sh_en[k];
          r_act_flip[k] <= r_sh_flip[k];
        end
      end
      if (bus.cfg_we && w_sel_ok) begin
        r_sh_x[bus.cfg_sel]    <= bus.cfg_x;
        r_sh_y[bus.cfg_sel]    <= bus.cfg_y;
        r_sh_en[bus.cfg_sel]   <= bus.cfg_en;
        r_sh_flip[bus.cfg_sel] <= bus.cfg_flip;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 0: per-channel hit test and ROM address
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < N_SPR; k++) begin : g_chan
    logic [10:0]       w_px;
    logic [10:0]       w_py;
    logic [10:0]       w_ox;
    logic [10:0]       w_oy;
    logic [10:0]       w_dx;
    logic [10:0]       w_dy;
    logic [10:0]       w_col;
    logic [ADDR_W-1:0] w_addr;

    // 11-bit zero-extended compares: the box end x+SPR_W can exceed 1023
    // without wrapping, so nothing near column 0 is falsely hit.
    assign w_px = {1'b0, DrawX};
    assign w_py = {1'b0, DrawY};
    assign w_ox = {1'b0, r_act_x[k]};
    assign w_oy = {1'b0, r_act_y[k]};
    assign w_dx = w_px - w_ox;
    assign w_dy = w_py - w_oy;

    assign w_hit[k] = r_act_en[k] &
                      (w_px >= w_ox) & (w_px < w_ox + C_SPR_W) &
                      (w_py >= w_oy) & (w_py < w_oy + C_SPR_H);

    assign w_col  = r_act_flip[k] ? (C_SPR_W - 11'd1 - w_dx) : w_dx;
    // The valid address range fits in ADDR_W, so modular arithmetic is exact
    assign w_addr = ADDR_W'(w_col) + ADDR_W'(w_dy) * ADDR_W'(C_SPR_W);

    assign bus.rom_addr[k*ADDR_W +: ADDR_W] = w_hit[k] ? w_addr : '0;

    assign w_q[k]      = bus.rom_q[k*IDX_W +: IDX_W];
    assign w_opaque[k] = r_hit_d[k] & (w_q[k] != C_TRANS);
  end

  // --------------------------------------------------------------------------
  // Stage 1: align hit flags with the synchronous ROM data
  // --------------------------------------------------------------------------
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_d <= '0;
    end else begin
      r_hit_d <= w_hit;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: fixed priority, lowest opaque channel wins
  // --------------------------------------------------------------------------
  always_comb begin
    w_win_on  = 1'b0;
    w_win_id  = '0;
    w_win_idx = '0;
    // Scan high to low so the lowest opaque channel is written last
    for (int k = N_SPR - 1; k >= 0; k--) begin
      if (w_opaque[k]) begin
        w_win_on  = 1'b1;
        w_win_id  = ID_W'(k);
        w_win_idx = w_q[k];
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sprite_on <= 1'b0;
      spr_id    <= '0;
      pix_idx   <= '0;
    end else begin
      sprite_on <= w_win_on;
      spr_id    <= w_win_id;
      pix_idx   <= w_win_idx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_layer_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_layer_renderer
// Purpose  : Directed, table-driven bench for sprite_layer_renderer with a
//            behavioural synchronous ROM per channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_layer_renderer;

  localparam int N_SPR  = 4;
  localparam int IDX_W  = 4;
  localparam int ADDR_W = 12;

  logic       vga_clk;
  logic       reset_n;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       frame_start;
  logic [3:0] pix_idx;
  logic [1:0] spr_id;
  logic       sprite_on;

  int vecs;
  int miscompares;

  sprite_layer_renderer_if #(.N_SPR(N_SPR), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) bus ();

  sprite_layer_renderer #(
    .N_SPR(N_SPR), .SPR_W(55), .SPR_H(55), .IDX_W(IDX_W), .TRANS(0), .ADDR_W(ADDR_W)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .frame_start (frame_start),
    .bus         (bus),
    .pix_idx     (pix_idx),
    .spr_id      (spr_id),
    .sprite_on   (sprite_on)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // ROM contents: (addr mod 15)+1, channel 1 shifted by 7; channel 0 is
  // transparent at address 5 only.
  function automatic logic [3:0] rom_val(input int ch, input int a);
    if (ch == 0 && a == 5) return 4'd0;
    return 4'((((ch == 1) ? a + 7 : a) % 15) + 1);
  endfunction

  always @(posedge vga_clk) begin
    for (int k = 0; k < N_SPR; k++)
      bus.rom_q[k*IDX_W +: IDX_W] <= rom_val(k, int'(bus.rom_addr[k*ADDR_W +: ADDR_W]));
  end

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] a0;
    logic [11:0] a1;
    logic        on;
    logic [1:0]  id;
    logic [3:0]  idx;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input int got, input int want);
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Presents one pixel, checks the combinational ROM addresses, then holds it
  // and checks the registered outputs two clocks later.
  task automatic check_pixel(input vec_t v, input string name);
    @(negedge vga_clk);
    DrawX = v.x;
    DrawY = v.y;
    #1;
    vecs++;
    chk({name, ".rom_addr0"}, int'(bus.rom_addr[11:0]),  int'(v.a0));
    chk({name, ".rom_addr1"}, int'(bus.rom_addr[23:12]), int'(v.a1));
    @(posedge vga_clk);
    @(posedge vga_clk);
    @(negedge vga_clk);
    chk({name, ".sprite_on"}, int'(sprite_on), int'(v.on));
    chk({name, ".spr_id"},    int'(spr_id),    int'(v.id));
    chk({name, ".pix_idx"},   int'(pix_idx),   int'(v.idx));
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) check_pixel(tbl[i], $sformatf("vec%0d", i));
  endtask

  task automatic cfg_write(input int sel, input int x, input int y, input bit en, input bit flip);
    @(negedge vga_clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = 2'(sel);
    bus.cfg_x    = 10'(x);
    bus.cfg_y    = 10'(y);
    bus.cfg_en   = en;
    bus.cfg_flip = flip;
    @(negedge vga_clk);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic frame_pulse();
    @(negedge vga_clk);
    frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
  endtask

  logic [9:0] s_x   [5];
  logic       s_on  [5];
  logic [3:0] s_idx [5];

  initial begin
    vecs        = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    DrawX       = '0;
    DrawY       = '0;
    frame_start = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_sel  = '0;
    bus.cfg_x    = '0;
    bus.cfg_y    = '0;
    bus.cfg_en   = 1'b0;
    bus.cfg_flip = 1'b0;

    //            x       y       a0        a1        on    id    idx
    tbl[0]  = '{10'd100, 10'd50,  12'd0,    12'd0,    1'b1, 2'd0, 4'd1};
    tbl[1]  = '{10'd154, 10'd104, 12'd3024, 12'd0,    1'b1, 2'd0, 4'd10};
    tbl[2]  = '{10'd155, 10'd104, 12'd0,    12'd0,    1'b0, 2'd0, 4'd0};
    tbl[3]  = '{10'd99,  10'd50,  12'd0,    12'd0,    1'b0, 2'd0, 4'd0};
    tbl[4]  = '{10'd100, 10'd49,  12'd0,    12'd0,    1'b0, 2'd0, 4'd0};
    tbl[5]  = '{10'd100, 10'd105, 12'd0,    12'd0,    1'b0, 2'd0, 4'd0};
    tbl[6]  = '{10'd110, 10'd60,  12'd560,  12'd0,    1'b1, 2'd0, 4'd6};
    tbl[7]  = '{10'd100, 10'd50,  12'd54,   12'd0,    1'b1, 2'd0, 4'd10};
    tbl[8]  = '{10'd154, 10'd50,  12'd0,    12'd0,    1'b1, 2'd0, 4'd1};
    tbl[9]  = '{10'd105, 10'd50,  12'd49,   12'd0,    1'b1, 2'd0, 4'd5};
    tbl[10] = '{10'd105, 10'd50,  12'd5,    12'd5,    1'b1, 2'd1, 4'd13};
    tbl[11] = '{10'd106, 10'd50,  12'd6,    12'd6,    1'b1, 2'd0, 4'd7};
    tbl[12] = '{10'd155, 10'd50,  12'd0,    12'd0,    1'b0, 2'd0, 4'd0};
    tbl[13] = '{10'd959, 10'd0,   12'd0,    12'd54,   1'b1, 2'd1, 4'd2};
    tbl[14] = '{10'd960, 10'd0,   12'd0,    12'd0,    1'b0, 2'd0, 4'd0};
    tbl[15] = '{10'd0,   10'd0,   12'd0,    12'd0,    1'b0, 2'd0, 4'd0};
    tbl[16] = '{10'd904, 10'd0,   12'd0,    12'd0,    1'b0, 2'd0, 4'd0};
    tbl[17] = '{10'd905, 10'd54,  12'd0,    12'd2970, 1'b1, 2'd1, 4'd8};

    // Reset state
    repeat (3) @(negedge vga_clk);
    vecs++;
    chk("reset.sprite_on", int'(sprite_on), 0);
    chk("reset.spr_id",    int'(spr_id),    0);
    chk("reset.pix_idx",   int'(pix_idx),   0);
    reset_n = 1'b1;

    // Basic placement of channel 0
    cfg_write(0, 100, 50, 1'b1, 1'b0);
    frame_pulse();
    run_range(0, 6);

    // X-flip
    cfg_write(0, 100, 50, 1'b1, 1'b1);
    frame_pulse();
    run_range(7, 9);

    // Overlap: channel 1 shows through channel 0's transparent pixel
    cfg_write(0, 100, 50, 1'b1, 1'b0);
    cfg_write(1, 100, 50, 1'b1, 1'b0);
    frame_pulse();
    run_range(10, 12);

    // Config write coinciding with frame_start: active keeps the old value
    cfg_write(1, 100, 50, 1'b0, 1'b0);
    @(negedge vga_clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = 2'd0;
    bus.cfg_x    = 10'd200;
    bus.cfg_y    = 10'd50;
    bus.cfg_en   = 1'b1;
    bus.cfg_flip = 1'b0;
    frame_start  = 1'b1;
    @(negedge vga_clk);
    bus.cfg_we   = 1'b0;
    frame_start  = 1'b0;
    check_pixel('{10'd100, 10'd50, 12'd0, 12'd0, 1'b1, 2'd0, 4'd1}, "same_cycle_old_hit");
    check_pixel('{10'd200, 10'd50, 12'd0, 12'd0, 1'b0, 2'd0, 4'd0}, "same_cycle_new_miss");
    frame_pulse();
    check_pixel('{10'd200, 10'd50, 12'd0, 12'd0, 1'b1, 2'd0, 4'd1}, "next_frame_hit");
    check_pixel('{10'd100, 10'd50, 12'd0, 12'd0, 1'b0, 2'd0, 4'd0}, "next_frame_old_miss");

    // Streaming at one pixel per clock: output i appears 2 clocks after input i
    s_x[0] = 10'd200; s_on[0] = 1'b1; s_idx[0] = 4'd1;
    s_x[1] = 10'd199; s_on[1] = 1'b0; s_idx[1] = 4'd0;
    s_x[2] = 10'd201; s_on[2] = 1'b1; s_idx[2] = 4'd2;
    s_x[3] = 10'd254; s_on[3] = 1'b1; s_idx[3] = 4'd10;
    s_x[4] = 10'd255; s_on[4] = 1'b0; s_idx[4] = 4'd0;
    for (int i = 0; i < 7; i++) begin
      @(negedge vga_clk);
      if (i >= 2) begin
        vecs++;
        chk($sformatf("stream%0d.sprite_on", i - 2), int'(sprite_on), int'(s_on[i-2]));
        chk($sformatf("stream%0d.pix_idx", i - 2),   int'(pix_idx),   int'(s_idx[i-2]));
      end
      if (i < 5) begin
        DrawX = s_x[i];
        DrawY = 10'd50;
      end
    end

    // Mid-line asynchronous reset
    check_pixel('{10'd200, 10'd50, 12'd0, 12'd0, 1'b1, 2'd0, 4'd1}, "pre_reset_hit");
    @(negedge vga_clk);
    #2;
    reset_n = 1'b0;
    #1;
    vecs++;
    chk("async_reset.sprite_on", int'(sprite_on), 0);
    chk("async_reset.pix_idx",   int'(pix_idx),   0);
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;
    check_pixel('{10'd200, 10'd50, 12'd0, 12'd0, 1'b0, 2'd0, 4'd0}, "post_reset_disabled");
    frame_pulse();
    check_pixel('{10'd0, 10'd0, 12'd0, 12'd0, 1'b0, 2'd0, 4'd0}, "post_reset_shadow_clear");

    // Right-edge sprite: no wrap towards column 0
    cfg_write(0, 0, 0, 1'b0, 1'b0);
    cfg_write(1, 905, 0, 1'b1, 1'b0);
    frame_pulse();
    run_range(13, 17);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
